// File: rtl/zmod_adc_spi_sched_pkg.sv
// Shared definitions for the ZMOD ADC (AD9648) SPI scheduler: frame layout,
// FSM states and the register addresses used by the requesters.
package zmod_adc_pkg;

  localparam int FRM_W    = 24;
  localparam int FRM_RW   = 23;
  localparam int FRM_W_HI = 22;
  localparam int FRM_W_LO = 21;
  localparam int FRM_A_HI = 20;
  localparam int FRM_A_LO = 8;
  localparam int FRM_D_HI = 7;
  localparam int FRM_D_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam logic [12:0] REG_CHSELECT = 13'h005;
  localparam logic [12:0] REG_PWRMODE  = 13'h008;
  localparam logic [12:0] REG_OMODE    = 13'h014;
  localparam logic [12:0] REG_TESTMODE = 13'h00D;

  function automatic logic frame_is_read(input logic [FRM_W-1:0] f);
    return f[FRM_RW];
  endfunction

endpackage

// File: rtl/zmod_adc_spi_sched_rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after ptr_i,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr_i) + i) % N);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zmod_adc_spi_sched.sv
// Round-robin scheduler serialising 24-bit AD9648 register frames onto the
// 3-wire SPI bus; returns the read byte for read frames.
module zmod_adc_spi_sched
  import zmod_adc_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [24*N_REQ-1:0]   i_frame,
  output logic [N_REQ-1:0]      o_gnt,
  output logic [N_REQ-1:0]      o_done,
  output logic [7:0]            o_rdata,
  output logic                  o_busy,
  output logic                  o_sck,
  output logic                  o_cs,
  output logic                  o_sdio,
  output logic                  o_sdio_oe,
  input  logic                  i_sdio
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HP_LAST  = HW'(CLK_DIV - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(N_REQ - 1);

  state_t             state_q, state_d;
  logic [HW-1:0]      hp_q, hp_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [FRM_W-1:0]   sh_q, sh_d;
  logic [7:0]         rsh_q, rsh_d;
  logic               rw_q, rw_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic               sck_q, sck_d, cs_q, cs_d, sdio_q, sdio_d, oe_q, oe_d;
  logic               busy_q, busy_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d, done_q, done_d;
  logic [7:0]         rdata_q, rdata_d;

  logic [N_REQ-1:0]   arb_gnt;
  logic               arb_valid;
  logic [PW-1:0]      sel_idx;
  logic [FRM_W-1:0]   sel_frame;
  logic               hp_last;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req_i   (i_req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  always_comb begin
    sel_idx   = '0;
    sel_frame = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_idx   = PW'(i);
        sel_frame = i_frame[24*i +: 24];
      end
    end
  end

  assign hp_last = (hp_q == HP_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      hp_q    <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      rsh_q   <= '0;
      rw_q    <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      sck_q   <= 1'b1;
      cs_q    <= 1'b1;
      sdio_q  <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rsh_q   <= rsh_d;
      rw_q    <= rw_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      sdio_q  <= sdio_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hp_d    = hp_last ? '0 : hp_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        hp_d = '0;
        if (arb_valid) state_d = ST_SETUP;
      end
      ST_SETUP: if (hp_last) state_d = ST_LOW;
      ST_LOW:   if (hp_last) state_d = ST_HIGH;
      ST_HIGH:  if (hp_last) state_d = (cnt_q == '0) ? ST_HOLD : ST_LOW;
      ST_HOLD:  if (hp_last) state_d = ST_GAP;
      ST_GAP:   if (hp_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so each pin value is produced on the edge that
  // enters the phase it belongs to.
  always_comb begin
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    rsh_d   = rsh_q;
    rw_d    = rw_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    sdio_d  = sdio_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    gnt_d   = '0;
    done_d  = '0;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        busy_d = arb_valid;
        if (arb_valid) begin
          gnt_d   = arb_gnt;
          sh_d    = sel_frame;
          rw_d    = frame_is_read(sel_frame);
          owner_d = sel_idx;
          ptr_d   = (sel_idx == IDX_LAST) ? '0 : sel_idx + 1'b1;
          cnt_d   = 5'd23;
          rsh_d   = '0;
          cs_d    = 1'b0;
          sck_d   = 1'b1;
          oe_d    = 1'b1;
          sdio_d  = sel_frame[FRM_RW];
        end
      end
      ST_SETUP: begin
        if (hp_last) begin
          sck_d  = 1'b0;
          sdio_d = sh_q[FRM_W-1];
        end
      end
      ST_LOW: if (hp_last) sck_d = 1'b1;
      ST_HIGH: begin
        if (hp_last) begin
          cnt_d = cnt_q - 1'b1;
          if (rw_q && cnt_q <= 5'd7) rsh_d = {rsh_q[6:0], i_sdio};
          if (cnt_q != '0) begin
            sck_d  = 1'b0;
            sh_d   = {sh_q[FRM_W-2:0], 1'b0};
            sdio_d = sh_q[FRM_W-2];
            // Release SDIO before the slave starts driving the data byte.
            if (rw_q && cnt_q == 5'd8) oe_d = 1'b0;
          end
        end
      end
      ST_HOLD: begin
        if (hp_last) begin
          cs_d   = 1'b1;
          oe_d   = 1'b0;
          sdio_d = 1'b0;
        end
      end
      ST_GAP: begin
        if (hp_last) begin
          done_d[owner_q] = 1'b1;
          if (rw_q) rdata_d = rsh_q;
        end
      end
      default: ;
    endcase
  end

  assign o_gnt     = gnt_q;
  assign o_done    = done_q;
  assign o_rdata   = rdata_q;
  assign o_busy    = busy_q;
  assign o_sck     = sck_q;
  assign o_cs      = cs_q;
  assign o_sdio    = sdio_q;
  assign o_sdio_oe = oe_q;

endmodule

// File: tb/tb_zmod_adc_spi_sched.sv
// Scoreboard bench for zmod_adc_spi_sched: expected grants/completions are
// queued at issue time and checked by monitors against an SPI slave model.
module tb_zmod_adc_spi_sched;

  localparam int N  = 3;
  localparam int D  = 4;
  localparam int D2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn = 1'b0;
  logic [N-1:0]      i_req = '0;
  logic [24*N-1:0]   i_frame = '0;
  logic [N-1:0]      o_gnt, o_done;
  logic [7:0]        o_rdata;
  logic              o_busy, o_sck, o_cs, o_sdio, o_sdio_oe;
  logic              i_sdio = 1'b0;

  logic [0:0]        i_req2 = '0;
  logic [23:0]       i_frame2 = '0;
  logic [0:0]        o_gnt2, o_done2;
  logic [7:0]        o_rdata2;
  logic              o_busy2, o_sck2, o_cs2, o_sdio2, o_sdio_oe2;
  logic              i_sdio2 = 1'b0;

  zmod_adc_spi_sched #(.N_REQ(N), .CLK_DIV(D)) dut (
    .clk(clk), .rstn(rstn), .i_req(i_req), .i_frame(i_frame),
    .o_gnt(o_gnt), .o_done(o_done), .o_rdata(o_rdata), .o_busy(o_busy),
    .o_sck(o_sck), .o_cs(o_cs), .o_sdio(o_sdio), .o_sdio_oe(o_sdio_oe),
    .i_sdio(i_sdio)
  );

  zmod_adc_spi_sched #(.N_REQ(1), .CLK_DIV(D2)) dut2 (
    .clk(clk), .rstn(rstn), .i_req(i_req2), .i_frame(i_frame2),
    .o_gnt(o_gnt2), .o_done(o_done2), .o_rdata(o_rdata2), .o_busy(o_busy2),
    .o_sck(o_sck2), .o_cs(o_cs2), .o_sdio(o_sdio2), .o_sdio_oe(o_sdio_oe2),
    .i_sdio(i_sdio2)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  typedef struct {
    int          idx;
    logic [23:0] frame;
    logic [7:0]  rdata;
  } exp_t;

  exp_t        exp_done[$];
  int          exp_gnt[$];
  logic [23:0] exp2[$];
  int          issued[N];
  int          granted[N];
  logic [7:0]  rd_byte = 8'h00;
  logic [7:0]  last_rd = 8'h00;

  // Requester model: each request is held until its grant is seen.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (o_gnt[k]) granted[k]++;
      i_req[k] = (issued[k] != granted[k]);
    end
  end

  // SPI slave: captures SDIO on SCK rise, drives rd_byte on SCK fall of a read.
  logic [23:0] cap = '0;
  int          bitcnt = 0;
  int          first_low = 99;
  int          hi_run = 0;
  bit          prev_sck = 1'b1;
  bit          started = 1'b0;
  bit          seen_frame = 1'b0;
  bit          is_rd = 1'b0;

  always @(negedge clk) begin
    if (o_cs) begin
      bitcnt  = 0;
      started = 1'b0;
      hi_run++;
    end else begin
      if (!started) begin
        started   = 1'b1;
        first_low = 99;
        if (seen_frame) check("cs_gap_min", 32'(hi_run >= D + 1), 1);
        seen_frame = 1'b1;
        hi_run     = 0;
      end
      if (o_sck && !prev_sck) begin
        cap = {cap[22:0], o_sdio};
        bitcnt++;
        if (bitcnt == 1) is_rd = o_sdio;
      end
      if (!o_sck && prev_sck) begin
        if (is_rd && bitcnt >= 16 && bitcnt <= 23) i_sdio = rd_byte[23-bitcnt];
        else i_sdio = 1'b0;
      end
      if (!o_sdio_oe && first_low == 99) first_low = bitcnt;
    end
    prev_sck = o_sck;
  end

  // Scoreboard monitor for the main instance.
  int          gnt_cyc = 0;
  bit          inflight = 1'b0;
  exp_t        e;
  logic [N-1:0] exp1h;

  always @(negedge clk) begin
    if (!o_busy) inflight = 1'b0;
    if (o_gnt != '0) begin
      check("gnt_while_busy", 32'(inflight), 0);
      check("busy_at_gnt", 32'(o_busy), 1);
      inflight = 1'b1;
      gnt_cyc  = cyc;
      if (exp_gnt.size() == 0) begin
        check("gnt_unexpected", 32'(o_gnt), 0);
      end else begin
        exp1h = '0;
        exp1h[exp_gnt.pop_front()] = 1'b1;
        check("gnt_order", 32'(o_gnt), 32'(exp1h));
      end
    end
    if (o_done != '0) begin
      inflight = 1'b0;
      if (exp_done.size() == 0) begin
        check("done_unexpected", 32'(o_done), 0);
      end else begin
        e = exp_done.pop_front();
        exp1h = '0;
        exp1h[e.idx] = 1'b1;
        check("done_owner", 32'(o_done), 32'(exp1h));
        check("sdio_frame", 32'(cap), 32'(e.frame));
        check("done_latency", 32'(cyc - gnt_cyc), 32'(51 * D));
        check("rdata", 32'(o_rdata), 32'(e.rdata));
        check("oe_first_low_bit", 32'(first_low), e.frame[23] ? 32'd16 : 32'd99);
      end
    end
  end

  // Monitor for the CLK_DIV=2 instance.
  logic [23:0] cap2 = '0;
  int          nr2 = 0, r1 = 0, r2 = 0, gnt2_cyc = 0, done2_cnt = 0;
  bit          prev2 = 1'b1;
  logic [23:0] f2;

  always @(negedge clk) begin
    if (o_gnt2[0]) gnt2_cyc = cyc;
    if (o_cs2) nr2 = 0;
    else if (o_sck2 && !prev2) begin
      cap2 = {cap2[22:0], o_sdio2};
      nr2++;
      if (nr2 == 1) r1 = cyc;
      if (nr2 == 2) r2 = cyc;
    end
    prev2 = o_sck2;
    if (o_done2[0]) begin
      done2_cnt++;
      if (exp2.size() == 0) begin
        check("div2_done_unexpected", 32'(o_done2), 0);
      end else begin
        f2 = exp2.pop_front();
        check("div2_frame", 32'(cap2), 32'(f2));
        check("div2_latency", 32'(cyc - gnt2_cyc), 32'(51 * D2));
        check("div2_sck_period", 32'(r2 - r1), 32'(2 * D2));
      end
    end
  end

  task automatic expect_txn(input int k, input logic [23:0] f);
    exp_t x;
    if (f[23]) last_rd = rd_byte;
    x.idx   = k;
    x.frame = f;
    x.rdata = last_rd;
    exp_gnt.push_back(k);
    exp_done.push_back(x);
  endtask

  task automatic issue(input int k, input logic [23:0] f);
    i_frame[24*k +: 24] = f;
    issued[k]++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(exp_done.size() == 0 && exp_gnt.size() == 0 && !o_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("wait_idle_timeout", 32'(exp_done.size()), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_sck", 32'(o_sck), 1);
    check("rst_cs", 32'(o_cs), 1);
    check("rst_sdio", 32'(o_sdio), 0);
    check("rst_oe", 32'(o_sdio_oe), 0);
    check("rst_gnt_done", 32'({o_gnt, o_done}), 0);
    check("rst_rdata_busy", 32'({o_rdata, o_busy}), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    expect_txn(0, 24'h000503);
    issue(0, 24'h000503);
    wait_idle();

    rd_byte = 8'h88;
    expect_txn(1, 24'h800100);
    issue(1, 24'h800100);
    wait_idle();

    // pointer now 2: req0 and req2 together
    expect_txn(2, 24'h000801);
    expect_txn(0, 24'h001431);
    issue(0, 24'h001431);
    issue(2, 24'h000801);
    wait_idle();

    // abort a transfer with reset 100 cycles after its grant
    exp_gnt.push_back(1);
    issue(1, 24'h000D05);
    n = 0;
    while (granted[1] != issued[1] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_gnt_seen", 32'(granted[1]), 32'(issued[1]));
    repeat (100) @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("abort_cs", 32'(o_cs), 1);
    check("abort_sck", 32'(o_sck), 1);
    @(negedge clk);
    rstn    = 1'b1;
    last_rd = 8'h00;
    repeat (300) @(negedge clk);

    expect_txn(2, 24'h000D05);
    issue(2, 24'h000D05);
    wait_idle();

    rd_byte = 8'h5A;
    for (int r = 0; r < 2; r++) begin
      expect_txn(0, 24'h000803);
      expect_txn(1, 24'h801400);
      expect_txn(2, 24'h001431);
    end
    for (int r = 0; r < 2; r++) begin
      issue(0, 24'h000803);
      issue(1, 24'h801400);
      issue(2, 24'h001431);
    end
    wait_idle();

    exp2.push_back(24'h001431);
    i_frame2 = 24'h001431;
    i_req2   = 1'b1;
    n = 0;
    while (!o_gnt2[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    i_req2 = 1'b0;
    check("div2_gnt_seen", 32'(o_gnt2), 1);
    n = 0;
    while (done2_cnt == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("div2_done_seen", 32'(done2_cnt), 1);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
